// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: host duty-write port of led_pwm_fader.
interface led_pwm_fader_if #(
  parameter int WIDTH = 8
) ();
  // Valid-only strobe: wr_en qualifies wr_ch/wr_data for exactly one cycle and
  // the fader always accepts it (implicit ready=1, no back-pressure ever).
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, wr_ch, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: multi-channel LED PWM with a shared prescaled period counter and
// duty updates applied only at period boundaries. Define LED_PWM_FADE_EN for the fade engine.
module led_pwm_fader #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1,
  parameter int FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pwm_fader_if.slave      wr,
  output logic [CHANNELS-1:0] out,
  output logic                period_start,
  output logic [CHANNELS-1:0] fade_busy
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                tick, boundary;

  logic [WIDTH-1:0]    pending_q [CHANNELS];
  logic [WIDTH-1:0]    pending_d [CHANNELS];
  logic [WIDTH-1:0]    target_q  [CHANNELS];
  logic [WIDTH-1:0]    target_d  [CHANNELS];
  logic [WIDTH-1:0]    active_q  [CHANNELS];
  logic [WIDTH-1:0]    active_d  [CHANNELS];
  logic [CHANNELS-1:0] dirty_q, dirty_d;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                period_start_q;

`ifdef LED_PWM_FADE_EN
  localparam logic [WIDTH:0] STEP = FADE_STEP[WIDTH:0];

  // Move act toward tgt by STEP, clamped at tgt; compares run one bit wider
  // so neither direction can wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] act,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0]   a, t;
    logic [WIDTH-1:0] res;
    a   = {1'b0, act};
    t   = {1'b0, tgt};
    res = tgt;
    if ((a < t) && ((a + STEP) < t)) begin
      res = act + STEP[WIDTH-1:0];
    end else if ((a > t) && ((a - t) > STEP)) begin
      res = act - STEP[WIDTH-1:0];
    end
    return res;
  endfunction
`endif

  always_comb begin
    tick     = (pre_q == PRE_LAST);
    boundary = tick && (cnt_q == '1);
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d    = tick ? cnt_q + WIDTH'(1) : cnt_q;
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr.wr_en && (wr.wr_ch == 4'(i));
    end
  end

  // Boundary consumes the pre-edge pending/dirty; a write on the same edge
  // re-arms dirty so it lands at the following boundary.
  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    active_d  = active_q;
    dirty_d   = dirty_q;
    out_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_hit[i]) begin
        pending_d[i] = wr.wr_data;
      end
      dirty_d[i] = wr_hit[i] | (dirty_q[i] & ~boundary);
      if (boundary && dirty_q[i]) begin
        target_d[i] = pending_q[i];
      end
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        active_d[i] = step_toward(active_q[i], target_q[i]);
`else
        active_d[i] = target_q[i];
`endif
      end
      out_d[i] = (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      dirty_q        <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= '0;
        target_q[i]  <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      dirty_q        <= dirty_d;
      out_q          <= out_d;
      period_start_q <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= pending_d[i];
        target_q[i]  <= target_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

`ifdef LED_PWM_FADE_EN
  logic [CHANNELS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy_d[i] = (active_q[i] != target_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign fade_busy = busy_q;
`else
  logic unused_fade_step;
  assign unused_fade_step = |FADE_STEP;
  assign fade_busy        = '0;
`endif

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench for led_pwm_fader (8-bit/prescale 1 main
// instance plus a 4-bit/prescale 3 instance); LED_PWM_FADE_EN selects the fade model.
module tb_led_pwm_fader;

  localparam int CH      = 4;
  localparam int WD      = 8;
  localparam int PER     = 256;
  localparam int FSTEP   = 20;
  localparam int EXP_W   = CH * WD + CH;
  localparam int P2_PER  = 48;
  localparam int P2_DUTY = 5;
  localparam int NTBL    = 12;
  localparam int NPER    = 20;
`ifdef LED_PWM_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0] out, fade_busy;
  logic          period_start;
  logic [0:0]    out2, busy2;
  logic          ps2;

  led_pwm_fader_if #(.WIDTH(WD)) wr_if ();
  led_pwm_fader_if #(.WIDTH(4))  wr2_if ();

  led_pwm_fader #(.CHANNELS(CH), .WIDTH(WD), .PRESCALE(1), .FADE_STEP(FSTEP)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr_if),
    .out(out), .period_start(period_start), .fade_busy(fade_busy)
  );

  led_pwm_fader #(.CHANNELS(1), .WIDTH(4), .PRESCALE(3), .FADE_STEP(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr(wr2_if),
    .out(out2), .period_start(ps2), .fade_busy(busy2)
  );

  // write schedule: period, offset in period (edge index), channel, data
  int tbl_per [NTBL] = '{3, 3, 3, 3, 7, 7, 7, 7, 8, 9, 10, 14};
  int tbl_off [NTBL] = '{10, 20, 30, 40, 5, 100, 150, 200, 0, 255, 50, 50};
  int tbl_ch  [NTBL] = '{0, 1, 2, 3, 0, 7, 4, 0, 3, 1, 2, 2};
  int tbl_dat [NTBL] = '{64, 255, 0, 7, 10, 99, 88, 200, 128, 3, 50, 0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int pend_m [CH];
  bit dirty_m [CH];
  int tgt_prev [CH];
  int act_m [CH];

  function automatic int fade_to(input int a, input int t);
    if (!FADE_ON) return t;
    if (a < t) return (a + FSTEP > t) ? t : a + FSTEP;
    if (a > t) return (a - t > FSTEP) ? a - FSTEP : t;
    return a;
  endfunction

  // After period N's writes are known: push expected duty/busy for period N+1.
  task automatic model_end_of_period();
    logic [EXP_W-1:0] e;
    int tgt_cur;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      tgt_cur     = dirty_m[c] ? pend_m[c] : tgt_prev[c];
      dirty_m[c]  = 1'b0;
      act_m[c]    = fade_to(act_m[c], tgt_prev[c]);
      e[c*WD +: WD] = WD'(act_m[c]);
      e[CH*WD + c]  = FADE_ON && (act_m[c] != tgt_cur);
      tgt_prev[c] = tgt_cur;
    end
    exp_q.push_back(e);
  endtask

  // monitor state
  bit mon_en = 1'b0;
  int cyc, pulse_n, p2_n, hi2, p2_duty;
  int hi_cnt [CH];
  logic [CH-1:0] busy_last;
  logic          busy2_last;

  task automatic close_window();
    logic [EXP_W-1:0] e, got;
    got = '0;
    for (int c = 0; c < CH; c++) begin
      got[c*WD +: WD] = WD'(hi_cnt[c]);
      hi_cnt[c] = 0;
    end
    got[CH*WD +: CH] = busy_last;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("duty_w%0d", pulse_n - 1), 64'(got[CH*WD-1:0]), 64'(e[CH*WD-1:0]));
      check_eq($sformatf("busy_w%0d", pulse_n - 1), 64'(got[EXP_W-1:CH*WD]), 64'(e[EXP_W-1:CH*WD]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (period_start) begin
        check_eq("ps_pos", 64'(cyc), 64'(PER * (pulse_n + 1)));
        pulse_n++;
        close_window();
      end
      for (int c = 0; c < CH; c++) begin
        if (out[c]) hi_cnt[c]++;
      end
      busy_last = fade_busy;
      if (ps2) begin
        check_eq("ps2_pos", 64'(cyc), 64'(P2_PER * (p2_n + 1)));
        check_eq($sformatf("duty2_w%0d", p2_n), 64'(hi2), 64'((p2_n >= 2) ? p2_duty * 3 : 0));
        check_eq($sformatf("busy2_w%0d", p2_n), 64'(busy2_last),
                 64'(FADE_ON && (p2_duty != 0) && (p2_n == 1)));
        p2_n++;
        hi2 = 0;
      end
      if (out2[0]) hi2++;
      busy2_last = busy2[0];
    end
  end

  // driver tasks
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    cyc     = -1;
    pulse_n = 0;
    p2_n    = 0;
    hi2     = 0;
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    mon_en  = 1'b1;
  endtask

  task automatic idle_bus();
    wr_if.wr_en    = 1'b0;
    wr_if.wr_ch    = '0;
    wr_if.wr_data  = '0;
    wr2_if.wr_en   = 1'b0;
    wr2_if.wr_ch   = '0;
    wr2_if.wr_data = '0;
  endtask

  task automatic run_phase(input int nper, input bit use_tbl);
    for (int c = 0; c < CH; c++) begin
      pend_m[c] = 0; dirty_m[c] = 1'b0; tgt_prev[c] = 0; act_m[c] = 0;
    end
    p2_duty = use_tbl ? P2_DUTY : 0;
    exp_q.push_back('0);
    for (int ei = 1; ei < nper * PER; ei++) begin
      @(negedge clk);
      idle_bus();
      if (use_tbl) begin
        for (int k = 0; k < NTBL; k++) begin
          if (tbl_per[k] * PER + tbl_off[k] == ei) begin
            wr_if.wr_en   = 1'b1;
            wr_if.wr_ch   = 4'(tbl_ch[k]);
            wr_if.wr_data = WD'(tbl_dat[k]);
            if (tbl_ch[k] < CH) begin
              pend_m[tbl_ch[k]]  = tbl_dat[k];
              dirty_m[tbl_ch[k]] = 1'b1;
            end
          end
        end
        if (ei == 1) begin
          wr2_if.wr_en   = 1'b1;
          wr2_if.wr_ch   = 4'd0;
          wr2_if.wr_data = 4'(P2_DUTY);
        end
      end
      if (ei % PER == PER - 1) model_end_of_period();
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic drain();
    for (int i = 0; i < 1500 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    idle_bus();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_ps", 64'(period_start), 64'd0);
    check_eq("rst_busy", 64'(fade_busy), 64'd0);
    check_eq("rst_out2", 64'(out2), 64'd0);

    release_reset();
    run_phase(NPER, 1'b1);
    drain();

    // asynchronous reset between clock edges while channels are driving high
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("arst_out", 64'(out), 64'd0);
    check_eq("arst_ps", 64'(period_start), 64'd0);
    check_eq("arst_busy", 64'(fade_busy), 64'd0);
    check_eq("arst_out2", 64'(out2), 64'd0);
    check_eq("arst_busy2", 64'(busy2), 64'd0);
    repeat (5) @(posedge clk);

    release_reset();
    run_phase(4, 1'b0);
    drain();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Multi-channel LED PWM generator with a shared prescaled period counter and glitch-free duty updates. Each channel's duty is written through a simple write port into a pending register. The new duty takes effect only at a period boundary, so no output ever sees a truncated or doubled pulse. An optional fade engine ramps each channel toward its written target by a fixed step per period. The block sits between the register/host interface and the LED pins.

## Interface
- `CHANNELS`, 4, number of independent PWM outputs (1..16)
- `WIDTH`, 8, duty/counter resolution in bits (2..16)
- `PRESCALE`, 1, clk cycles per counter step (1..65535)
- `FADE_STEP`, 1, duty change per period when fading (1..2^WIDTH-1)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  duty write strobe, one write per clk cycle
- `wr_ch`  in  4  target channel index; values >= CHANNELS are ignored
- `wr_data`  in  WIDTH  duty value (fade build: target duty)
- `out`  out  CHANNELS  PWM outputs, bit i = channel i, active high
- `period_start`  out  1  one-clk pulse at each period boundary
- `fade_busy`  out  CHANNELS  bit i high while channel i active duty != target

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 and wraps. A `tick` occurs when `pre` == PRESCALE-1. With PRESCALE=1, every clk is a tick.
- Period counter `cnt` (WIDTH bits) increments on each tick and wraps from 2^WIDTH-1 to 0.
- Period = PRESCALE * 2^WIDTH clk cycles.
- Boundary event: a tick while `cnt` == 2^WIDTH-1.
- Per channel there are three registers: `pending`, `target`, and `active` (all WIDTH bits).
- Write with `wr_en`=1 and a valid `wr_ch` loads `pending[wr_ch]` and sets that channel's `dirty` flag. Multiple writes in one period: the last write wins.
- At a boundary event, every channel with `dirty` set copies `pending` to `target` and clears `dirty`.
- `active` is updated at the same boundary, from the value `target` held before that edge (non-fade build: `active <= target`, giving a one-period pipeline; see Timing).
- Compare: `out[i]` is registered as (`cnt` < `active[i]`).
  - duty 0: output constantly low.
  - duty 2^WIDTH-1: output high for 2^WIDTH-1 of 2^WIDTH steps. Full-on is not supported by design.
- Write on the same edge as a boundary: the boundary consumes the prior `pending`/`dirty`. The new write lands in `pending` with `dirty` set and is applied at the following boundary.
- `fade_busy[i]` = registered (`active[i]` != `target[i]`).

## Timing
- Reset state (asynchronous, `rst_n`=0):
  - `pre`, `cnt`, `pending`, `target`, `active`, and `dirty` are all 0.
  - `out` = 0, `period_start` = 0, `fade_busy` = 0.
- `out` lags `cnt` by one clk. The first period after reset is all-low.
- `period_start` is asserted for exactly one clk, in the cycle immediately after the boundary edge, i.e. while `cnt` = 0 and `pre` = 0.
- Write-to-effect latency:
  - Write in period N → `target` updated at the end of N → `active` updated at the end of N+1 → visible on `out` in period N+2.
  - This latency is fixed and independent of write timing within the period.
- Reset deassertion mid-period: counting restarts from 0. There is no partial-period carry-over.
- No combinational path from inputs to outputs.

## Configuration
- `LED_PWM_FADE_EN` defined: at each boundary, per channel, `active` moves toward `target` by FADE_STEP.
  - Arithmetic in WIDTH+1 bits.
  - Result clamped to `target`, never overshooting and never wrapping.
  - `fade_busy[i]` is high from the boundary where `target` changes until `active` reaches it.
- `LED_PWM_FADE_EN` undefined: `active <= target` directly at each boundary, FADE_STEP is unused, and `fade_busy` is tied to 0.

## Test plan
- Reset/idle: `rst_n` low 5 clks, then high, no writes → `out` = 0, `fade_busy` = 0 for 3 periods; `period_start` pulses every 256 clks (WIDTH=8, PRESCALE=1).
- Duty check: write ch0=64, ch1=255, ch2=0 → from period N+2, ch0 high 64/256 clks, ch1 high 255/256, ch2 never high. Duty is stable across 4 periods with no glitch at the boundary.
- Update timing: write ch0=10 then ch0=200 in the same period, plus write ch3=128 on the exact boundary edge → ch0 shows 200 (10 never appears); ch3 changes one period later than ch0. A write to `wr_ch`=7 (CHANNELS=4) has no effect.
- Prescaler: PRESCALE=3, WIDTH=4, duty 5 → period 48 clks, high 15 clks, `period_start` spacing 48.
- Fade (`LED_PWM_FADE_EN`, FADE_STEP=20): `active` 0, write 50 → successive periods show 20, 40, 50. `fade_busy[0]` is high through the ramp and low once at 50. Writing 0 then steps down 30, 10, 0 with no underflow.
- Async reset mid-ramp: assert `rst_n` low at an arbitrary cycle within a fade → all outputs are 0 immediately, without waiting for a clk edge, and the block restarts cleanly.
